ahb_bridge_arbiter: RTL and testbench

//  Two-master AHB arbiter sharing one ahb_avalon_bridge_with_burst slave port.

---
 rtl/ahb_bridge_arbiter_if.sv | 51 +++++
 rtl/ahb_bridge_arbiter.sv | 149 ++++++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bridge_arbiter_if.sv
// Bus bundle between two AHB masters, the arbiter and the shared bridge slave port.
// The arbiter uses the slave modport; the master modport drives the opposite side.
interface ahb_bridge_arbiter_if #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32
);
  // master-side request/grant
  logic [1:0]              hbusreq;
  logic [1:0]              hlock;
  logic [1:0]              hgrant;
  logic                    hmaster;

  // per-master address/control/data, packed master-major
  logic [3:0]              m_htrans;
  logic [2*ADDRESSWIDTH-1:0] m_haddr;
  logic [1:0]              m_hwrite;
  logic [5:0]              m_hsize;
  logic [5:0]              m_hburst;
  logic [2*DATAWIDTH-1:0]  m_hwdata;

  // broadcast back to both masters
  logic                    hready;
  logic [DATAWIDTH-1:0]    hrdata;

  // bridge slave port
  logic [1:0]              s_htrans;
  logic [ADDRESSWIDTH-1:0] s_haddr;
  logic                    s_hwrite;
  logic [2:0]              s_hsize;
  logic [2:0]              s_hburst;
  logic [DATAWIDTH-1:0]    s_hwdata;
  logic                    s_hsel;
  logic                    s_hreadyout;
  logic [DATAWIDTH-1:0]    s_hrdata;

  modport slave (
    input  hbusreq, hlock,
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  s_hreadyout, s_hrdata,
    output hgrant, hmaster, hready, hrdata,
    output s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hwdata, s_hsel
  );

  modport master (
    output hbusreq, hlock,
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output s_hreadyout, s_hrdata,
    input  hgrant, hmaster, hready, hrdata,
    input  s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hwdata, s_hsel
  );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Two-master AHB arbiter in front of one bridge slave port: per-burst round-robin
// grant with HLOCK retention, address mux by hmaster, write-data mux by data owner.
module ahb_bridge_arbiter #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  ahb_bridge_arbiter_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    logic [3:0] len;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
      default:                      len = 4'd0;
    endcase
    return len;
  endfunction

  // per-master views of the packed input buses
  logic [1:0]              htrans_arr [2];
  logic [ADDRESSWIDTH-1:0] haddr_arr  [2];
  logic                    hwrite_arr [2];
  logic [2:0]              hsize_arr  [2];
  logic [2:0]              hburst_arr [2];
  logic [DATAWIDTH-1:0]    hwdata_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign htrans_arr[gi] = bus.m_htrans[gi*2 +: 2];
      assign haddr_arr[gi]  = bus.m_haddr[gi*ADDRESSWIDTH +: ADDRESSWIDTH];
      assign hwrite_arr[gi] = bus.m_hwrite[gi];
      assign hsize_arr[gi]  = bus.m_hsize[gi*3 +: 3];
      assign hburst_arr[gi] = bus.m_hburst[gi*3 +: 3];
      assign hwdata_arr[gi] = bus.m_hwdata[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  logic [1:0] hgrant_reg;
  logic       hmaster_reg;
  logic       data_owner_reg;
  logic [3:0] beat_cnt_reg;
  logic [3:0] beat_cnt_next;
  logic       last_reg;
  logic       grant_idx_next;

  logic       owner_granted;
  logic [1:0] owner_htrans;
  logic [2:0] owner_hburst;
  logic       fixed_burst;
  logic       final_beat;
  logic       boundary;

  // The address-phase owner only counts once it also holds the grant; during a
  // handover cycle its htrans is ignored and IDLE is presented to the bridge.
  assign owner_granted = hgrant_reg[hmaster_reg];
  assign owner_htrans  = owner_granted ? htrans_arr[hmaster_reg] : HTRANS_IDLE;
  assign owner_hburst  = hburst_arr[hmaster_reg];
  assign fixed_burst   = (owner_hburst[2:1] != 2'b00);
  assign final_beat    = (owner_htrans == HTRANS_SEQ) && fixed_burst && (beat_cnt_reg == 4'd1);

  always_comb begin
    boundary = 1'b0;
    if (owner_granted) begin
      case (owner_htrans)
        HTRANS_IDLE:   boundary = 1'b1;
        HTRANS_BUSY:   boundary = 1'b0;
        HTRANS_NONSEQ: boundary = (owner_hburst == HBURST_SINGLE) ||
                                  ((owner_hburst == HBURST_INCR) && !bus.hbusreq[hmaster_reg]);
        default:       boundary = final_beat;
      endcase
    end
  end

  // Lock retention first, then the requester that was not granted last, else park on M0.
  always_comb begin
    grant_idx_next = 1'b0;
    if (bus.hlock[hmaster_reg] && bus.hbusreq[hmaster_reg]) begin
      grant_idx_next = hmaster_reg;
    end else if (bus.hbusreq[~last_reg]) begin
      grant_idx_next = ~last_reg;
    end else if (bus.hbusreq[last_reg]) begin
      grant_idx_next = last_reg;
    end
  end

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (owner_htrans == HTRANS_NONSEQ) begin
      beat_cnt_next = burst_len_m1(owner_hburst);
    end else if ((owner_htrans == HTRANS_SEQ) && (beat_cnt_reg != 4'd0)) begin
      beat_cnt_next = beat_cnt_reg - 4'd1;
    end
  end

  // Everything advances only on accepted cycles so a bridge stall freezes the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hgrant_reg     <= 2'b01;
      hmaster_reg    <= 1'b0;
      data_owner_reg <= 1'b0;
      beat_cnt_reg   <= 4'd0;
      last_reg       <= 1'b1;
    end else if (bus.s_hreadyout) begin
      data_owner_reg <= hmaster_reg;
      hmaster_reg    <= hgrant_reg[1];
      beat_cnt_reg   <= beat_cnt_next;
      if (boundary) begin
        hgrant_reg <= grant_idx_next ? 2'b10 : 2'b01;
        if (|bus.hbusreq) begin
          last_reg <= grant_idx_next;
        end
      end
    end
  end

  assign bus.hgrant  = hgrant_reg;
  assign bus.hmaster = hmaster_reg;
  assign bus.hready  = bus.s_hreadyout;
  assign bus.hrdata  = bus.s_hrdata;

  // Select is killed combinationally by reset so the bridge sees nothing mid-reset.
  assign bus.s_htrans = reset_n ? owner_htrans : HTRANS_IDLE;
  assign bus.s_hsel   = reset_n && owner_htrans[1];
  assign bus.s_haddr  = haddr_arr[hmaster_reg];
  assign bus.s_hwrite = hwrite_arr[hmaster_reg];
  assign bus.s_hsize  = hsize_arr[hmaster_reg];
  assign bus.s_hburst = hburst_arr[hmaster_reg];
  assign bus.s_hwdata = hwdata_arr[data_owner_reg];

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter: reactive master stimulus with
// hand-computed grant, owner, address and write-data expectations.
module tb_ahb_bridge_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR8  = 3'b101;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  ahb_bridge_arbiter_if #(.ADDRESSWIDTH(32), .DATAWIDTH(32)) bus ();

  ahb_bridge_arbiter #(.ADDRESSWIDTH(32), .DATAWIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] b, input logic [31:0] d);
    bus.m_htrans[i*2 +: 2]  = tr;
    bus.m_haddr[i*32 +: 32] = a;
    bus.m_hwrite[i]         = w;
    bus.m_hsize[i*3 +: 3]   = 3'b010;
    bus.m_hburst[i*3 +: 3]  = b;
    bus.m_hwdata[i*32 +: 32] = d;
  endtask

  task automatic reset_dut(input logic [1:0] req);
    reset_n         = 1'b0;
    bus.hbusreq     = req;
    bus.hlock       = 2'b00;
    bus.s_hreadyout = 1'b1;
    bus.s_hrdata    = 32'h1234_5678;
    drive_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'hDEAD_0000);
    drive_m(1, IDLE, 32'h0, 1'b0, SINGLE, 32'hDEAD_0001);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    bus.hbusreq     = 2'b00;
    bus.hlock       = 2'b00;
    bus.s_hreadyout = 1'b1;
    bus.s_hrdata    = 32'hCAFE_0001;
    drive_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'h0);
    drive_m(1, IDLE, 32'h0, 1'b0, SINGLE, 32'h0);
    tick();
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL reset_hgrant: got %b want 01", bus.hgrant); end
    total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL reset_hmaster: got %b want 0", bus.hmaster); end
    total++; if (bus.s_hsel !== 1'b0) begin bad++; $display("FAIL reset_hsel: got %b want 0", bus.s_hsel); end
    total++; if (bus.hrdata !== 32'hCAFE_0001) begin bad++; $display("FAIL reset_hrdata: got %h want cafe0001", bus.hrdata); end
    bus.s_hreadyout = 1'b0;
    #1;
    total++; if (bus.hready !== 1'b0) begin bad++; $display("FAIL reset_hready: got %b want 0", bus.hready); end
    bus.s_hreadyout = 1'b1;
    $display("reset: hgrant=%b hmaster=%b", bus.hgrant, bus.hmaster);
  endtask

  task automatic test_single_master();
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    reset_dut(2'b01);
    drive_m(0, NONSEQ, 32'h100, 1'b1, INCR4, 32'h0);
    drive_m(1, IDLE, 32'h0, 1'b0, SINGLE, 32'hBAD1_BAD1);
    #1;
    total++; if (bus.s_haddr !== 32'h100) begin bad++; $display("FAIL t1_addr0: got %h want 00000100", bus.s_haddr); end
    total++; if (bus.s_htrans !== NONSEQ) begin bad++; $display("FAIL t1_trans0: got %b want 10", bus.s_htrans); end
    total++; if (bus.s_hsel !== 1'b1) begin bad++; $display("FAIL t1_hsel0: got %b want 1", bus.s_hsel); end
    total++; if (bus.s_hburst !== INCR4) begin bad++; $display("FAIL t1_burst0: got %b want 011", bus.s_hburst); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_a = 32'h100 + 32'(4 * k);
      exp_d = 32'hA000_0000 + 32'(k - 1);
      drive_m(0, (k < 4) ? SEQ : IDLE, exp_a, 1'b1, INCR4, exp_d);
      #1;
      total++; if (bus.s_hwdata !== exp_d) begin bad++; $display("FAIL t1_wdata: beat %0d got %h want %h", k - 1, bus.s_hwdata, exp_d); end
      total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t1_grant: beat %0d got %b want 01", k, bus.hgrant); end
      if (k < 4) begin
        total++; if (bus.s_haddr !== exp_a) begin bad++; $display("FAIL t1_addr: beat %0d got %h want %h", k, bus.s_haddr, exp_a); end
        total++; if (bus.s_hwrite !== 1'b1) begin bad++; $display("FAIL t1_write: beat %0d got %b want 1", k, bus.s_hwrite); end
      end
      $display("t1 beat %0d wdata=%h", k - 1, bus.s_hwdata);
    end
    total++; if (bus.s_hsel !== 1'b0) begin bad++; $display("FAIL t1_hsel_end: got %b want 0", bus.s_hsel); end
  endtask

  task automatic test_round_robin();
    int          nxf;
    logic [1:0]  exp_g;
    logic        exp_m;
    logic [31:0] exp_a;
    reset_dut(2'b11);
    nxf = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if ((int'(bus.hmaster) == i) && bus.hgrant[i])
          drive_m(i, NONSEQ, 32'h200 + 32'(16 * i), 1'b0, SINGLE, 32'h0);
        else
          drive_m(i, IDLE, 32'h0, 1'b0, SINGLE, 32'h0);
      end
      bus.s_hrdata = 32'h5000_0000 + 32'(cyc);
      #1;
      if (bus.s_htrans == NONSEQ) begin
        exp_g = (nxf % 2 == 0) ? 2'b01 : 2'b10;
        exp_m = (nxf % 2 == 1);
        exp_a = 32'h200 + ((nxf % 2 == 1) ? 32'h10 : 32'h0);
        total++; if (bus.hgrant !== exp_g) begin bad++; $display("FAIL t2_grant: xfer %0d got %b want %b", nxf, bus.hgrant, exp_g); end
        total++; if (bus.hmaster !== exp_m) begin bad++; $display("FAIL t2_hmaster: xfer %0d got %b want %b", nxf, bus.hmaster, exp_m); end
        total++; if (bus.s_haddr !== exp_a) begin bad++; $display("FAIL t2_addr: xfer %0d got %h want %h", nxf, bus.s_haddr, exp_a); end
        $display("t2 xfer %0d hgrant=%b hmaster=%b addr=%h", nxf, bus.hgrant, bus.hmaster, bus.s_haddr);
        nxf++;
      end
      total++; if (bus.hrdata !== 32'h5000_0000 + 32'(cyc)) begin bad++; $display("FAIL t2_hrdata: got %h want %h", bus.hrdata, 32'h5000_0000 + 32'(cyc)); end
      tick();
    end
    total++; if (nxf != 4) begin bad++; $display("FAIL t2_xfer_count: got %0d want 4", nxf); end
  endtask

  task automatic test_hold_burst();
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    reset_dut(2'b01);
    bus.hbusreq = 2'b11;
    drive_m(0, NONSEQ, 32'h300, 1'b1, INCR8, 32'h0);
    #1;
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t3_grant0: got %b want 01", bus.hgrant); end
    for (int k = 1; k < 8; k++) begin
      tick();
      exp_a = 32'h300 + 32'(4 * k);
      exp_d = 32'hB000_0000 + 32'(k - 1);
      drive_m(0, SEQ, exp_a, 1'b1, INCR8, exp_d);
      #1;
      total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t3_grant: beat %0d got %b want 01", k, bus.hgrant); end
      total++; if (bus.s_haddr !== exp_a) begin bad++; $display("FAIL t3_addr: beat %0d got %h want %h", k, bus.s_haddr, exp_a); end
      total++; if (bus.s_hwdata !== exp_d) begin bad++; $display("FAIL t3_wdata: beat %0d got %h want %h", k - 1, bus.s_hwdata, exp_d); end
      $display("t3 beat %0d addr=%h", k, bus.s_haddr);
    end
    tick();
    drive_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'hB000_0007);
    #1;
    total++; if (bus.hgrant !== 2'b10) begin bad++; $display("FAIL t3_handover: got %b want 10", bus.hgrant); end
    total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL t3_hmaster_old: got %b want 0", bus.hmaster); end
    total++; if (bus.s_hwdata !== 32'hB000_0007) begin bad++; $display("FAIL t3_last_wdata: got %h want b0000007", bus.s_hwdata); end
    total++; if (bus.s_hsel !== 1'b0) begin bad++; $display("FAIL t3_hsel: got %b want 0", bus.s_hsel); end
    tick();
    total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL t3_hmaster_new: got %b want 1", bus.hmaster); end
  endtask

  task automatic test_stall();
    reset_dut(2'b01);
    bus.hbusreq = 2'b11;
    drive_m(0, NONSEQ, 32'h400, 1'b0, INCR4, 32'h0);
    tick();
    drive_m(0, SEQ, 32'h404, 1'b0, INCR4, 32'h0);
    tick();
    drive_m(0, SEQ, 32'h408, 1'b0, INCR4, 32'h0);
    bus.s_hreadyout = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t4_grant: stall %0d got %b want 01", c, bus.hgrant); end
      total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL t4_hmaster: stall %0d got %b want 0", c, bus.hmaster); end
      total++; if (bus.s_haddr !== 32'h408) begin bad++; $display("FAIL t4_addr: stall %0d got %h want 00000408", c, bus.s_haddr); end
      total++; if (bus.hready !== 1'b0) begin bad++; $display("FAIL t4_hready: stall %0d got %b want 0", c, bus.hready); end
      $display("t4 stall %0d addr=%h", c, bus.s_haddr);
      tick();
    end
    bus.s_hreadyout = 1'b1;
    #1;
    total++; if (bus.s_haddr !== 32'h408) begin bad++; $display("FAIL t4_addr_release: got %h want 00000408", bus.s_haddr); end
    tick();
    drive_m(0, SEQ, 32'h40C, 1'b0, INCR4, 32'h0);
    #1;
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t4_grant_last: got %b want 01", bus.hgrant); end
    tick();
    drive_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'h0);
    #1;
    total++; if (bus.hgrant !== 2'b10) begin bad++; $display("FAIL t4_grant_after: got %b want 10", bus.hgrant); end
  endtask

  task automatic test_locked();
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    reset_dut(2'b10);
    tick();
    total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL t5_hmaster0: got %b want 1", bus.hmaster); end
    bus.hbusreq = 2'b11;
    bus.hlock   = 2'b10;
    for (int n = 0; n < 8; n++) begin
      exp_a = ((n < 4) ? 32'h500 : 32'h600) + 32'(4 * (n % 4));
      exp_d = 32'hC000_0000 + 32'(n - 1);
      if (n == 4) bus.hlock = 2'b00;
      drive_m(1, (n % 4 == 0) ? NONSEQ : SEQ, exp_a, 1'b1, INCR4, exp_d);
      #1;
      total++; if (bus.hgrant !== 2'b10) begin bad++; $display("FAIL t5_grant: beat %0d got %b want 10", n, bus.hgrant); end
      total++; if (bus.hmaster !== 1'b1) begin bad++; $display("FAIL t5_hmaster: beat %0d got %b want 1", n, bus.hmaster); end
      total++; if (bus.s_haddr !== exp_a) begin bad++; $display("FAIL t5_addr: beat %0d got %h want %h", n, bus.s_haddr, exp_a); end
      if (n > 0) begin
        total++; if (bus.s_hwdata !== exp_d) begin bad++; $display("FAIL t5_wdata: beat %0d got %h want %h", n - 1, bus.s_hwdata, exp_d); end
      end
      $display("t5 beat %0d addr=%h", n, bus.s_haddr);
      tick();
    end
    drive_m(1, IDLE, 32'h0, 1'b0, SINGLE, 32'hC000_0007);
    #1;
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t5_handover: got %b want 01", bus.hgrant); end
    total++; if (bus.s_hwdata !== 32'hC000_0007) begin bad++; $display("FAIL t5_last_wdata: got %h want c0000007", bus.s_hwdata); end
    tick();
    total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL t5_hmaster_new: got %b want 0", bus.hmaster); end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut(2'b10);
    tick();
    drive_m(1, NONSEQ, 32'h700, 1'b1, WRAP8, 32'h0);
    tick();
    drive_m(1, SEQ, 32'h704, 1'b1, WRAP8, 32'h0);
    drive_m(0, NONSEQ, 32'h7F0, 1'b0, SINGLE, 32'h0);
    #1;
    total++; if (bus.s_haddr !== 32'h704) begin bad++; $display("FAIL t6_addr_beat2: got %h want 00000704", bus.s_haddr); end
    total++; if (bus.s_hsel !== 1'b1) begin bad++; $display("FAIL t6_hsel_beat2: got %b want 1", bus.s_hsel); end
    reset_n = 1'b0;
    #1;
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t6_async_grant: got %b want 01", bus.hgrant); end
    total++; if (bus.hmaster !== 1'b0) begin bad++; $display("FAIL t6_async_hmaster: got %b want 0", bus.hmaster); end
    total++; if (bus.s_hsel !== 1'b0) begin bad++; $display("FAIL t6_async_hsel: got %b want 0", bus.s_hsel); end
    $display("t6 reset asserted hgrant=%b hmaster=%b", bus.hgrant, bus.hmaster);
    tick();
    drive_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'h0);
    bus.hbusreq = 2'b00;
    reset_n = 1'b1;
    tick();
    total++; if (bus.hgrant !== 2'b01) begin bad++; $display("FAIL t6_post_grant: got %b want 01", bus.hgrant); end
    total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL t6_ungranted_trans: got %b want 00", bus.s_htrans); end
    total++; if (bus.s_hsel !== 1'b0) begin bad++; $display("FAIL t6_post_hsel: got %b want 0", bus.s_hsel); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    test_reset();
    test_single_master();
    test_round_robin();
    test_hold_burst();
    test_stall();
    test_locked();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
